life_grid_reader: RTL and testbench

//  Read-side counterpart to the cell-grid writer: snapshots the full W x H Game-of-Life grid
//  on request and streams it out one row per beat over a valid/ready handshake.

---
 rtl/life_grid_reader_pkg.sv | 15 +
 rtl/life_grid_reader_dff.sv | 16 +
 rtl/life_grid_reader.sv | 118 +++++++++++
 tb/tb_life_grid_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_grid_reader_pkg.sv
// Shared types and width helpers for the life grid reader.
package life_grid_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  // Width of an index/count that must hold at least one bit even for n <= 1.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/life_grid_reader_dff.sv
// Plain W-bit register with synchronous active-low clear; holds the grid snapshot.
module life_grid_reader_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!_rst) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/life_grid_reader.sv
// Snapshots a W x H life grid on start and streams it one row per beat (LIFE_READER_POPCOUNT_EN adds pop counts).
// Latency: first row valid 1 cycle after start; done pulses 1 cycle after the last beat is accepted.
// Backpressure: out_row/out_idx/out_last hold while out_valid & !out_ready; start outside IDLE is dropped.
module life_grid_reader
  import life_grid_reader_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int H  = 8,
  localparam int RW = safe_clog2(H)
`ifdef LIFE_READER_POPCOUNT_EN
  ,
  localparam int PW = safe_clog2(W + 1),
  localparam int FW = safe_clog2(W * H + 1)
`endif
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic [W*H-1:0]  grid,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_row,
  output logic [RW-1:0]   out_idx,
  output logic            out_last,
`ifdef LIFE_READER_POPCOUNT_EN
  output logic [PW-1:0]   out_pop,
  output logic [FW-1:0]   frame_pop,
`endif
  output logic            done
);

  localparam int SW = safe_clog2(W * H);

  state_t           state;
  logic             capture;
  logic [W*H-1:0]   snap_d;
  logic [W*H-1:0]   snap_q;
  logic [SW-1:0]    row_base;

  assign capture = (state == ST_IDLE) && start;
  assign snap_d  = capture ? grid : snap_q;

  life_grid_reader_dff #(
    .W (W * H)
  ) u_snap (
    .clk  (clk),
    ._rst (_rst),
    .d    (snap_d),
    .q    (snap_q)
  );

  always_comb begin
    row_base = SW'(out_idx) * SW'(W);
    out_row  = snap_q[row_base +: W];
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEND;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= (H == 1);
          end
        end
        ST_SEND: begin
          // out_valid is always high here, so out_ready alone marks a handshake.
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= out_idx + 1'b1;
              out_last <= (int'(out_idx) + 2 == H);
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          out_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LIFE_READER_POPCOUNT_EN
  logic [FW-1:0] snap_pop;

  always_comb begin
    out_pop = '0;
    for (int c = 0; c < W; c++) out_pop = out_pop + PW'(out_row[c]);
    snap_pop = '0;
    for (int b = 0; b < W * H; b++) snap_pop = snap_pop + FW'(snap_q[b]);
  end

  always_ff @(posedge clk) begin
    if (!_rst)                                       frame_pop <= '0;
    else if (state == ST_SEND && out_ready && out_last) frame_pop <= snap_pop;
  end
`endif

endmodule

// File: tb/tb_life_grid_reader.sv
// Self-checking bench: 4x3 reader for framing/backpressure/reset, 8x1 reader for the single-row case.
module tb_life_grid_reader;

  localparam int AW = 4;
  localparam int AH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] a_grid;
  logic        a_start, a_busy, a_valid, a_ready, a_last, a_done;
  logic [3:0]  a_row;
  logic [1:0]  a_idx;
  logic [7:0]  b_grid;
  logic        b_start, b_busy, b_valid, b_ready, b_last, b_done;
  logic [7:0]  b_row;
  logic [0:0]  b_idx;
`ifdef LIFE_READER_POPCOUNT_EN
  logic [2:0]  a_pop;
  logic [3:0]  a_fpop;
  logic [3:0]  b_pop;
  logic [3:0]  b_fpop;
`endif

  int checks   = 0;
  int failures = 0;

  life_grid_reader #(.W(AW), .H(AH)) dut_a (
    .clk       (clk),
    ._rst      (rst_n),
    .grid      (a_grid),
    .start     (a_start),
    .busy      (a_busy),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_row   (a_row),
    .out_idx   (a_idx),
    .out_last  (a_last),
`ifdef LIFE_READER_POPCOUNT_EN
    .out_pop   (a_pop),
    .frame_pop (a_fpop),
`endif
    .done      (a_done)
  );

  life_grid_reader #(.W(8), .H(1)) dut_b (
    .clk       (clk),
    ._rst      (rst_n),
    .grid      (b_grid),
    .start     (b_start),
    .busy      (b_busy),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_row   (b_row),
    .out_idx   (b_idx),
    .out_last  (b_last),
`ifdef LIFE_READER_POPCOUNT_EN
    .out_pop   (b_pop),
    .frame_pop (b_fpop),
`endif
    .done      (b_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_valid"}, a_valid, 1'b0);
    chk({tag, "_busy"},  a_busy,  1'b0);
    chk({tag, "_done"},  a_done,  1'b0);
    chk({tag, "_last"},  a_last,  1'b0);
  endtask

  // mode 0: always ready, 1: random ready, 2: five stall cycles on row 1.
  task automatic run_frame(input logic [11:0] g, input int mode, input bit flood);
    int   beat  = 0;
    int   cyc   = 0;
    int   stall = 0;
    logic [3:0] exp_row;
    a_grid  = g;
    a_start = 1'b1;
    a_ready = 1'b0;
    tick();
    a_start = 1'b0;
    a_grid  = flood ? 12'hFFF : 12'($urandom);
    while (beat < AH) begin
      if (cyc++ > 100) begin
        chk("frame_timeout", 64'(beat), 64'(AH));
        break;
      end
      exp_row = 4'((g >> (beat * AW)) & 12'hF);
      chk("a_valid", a_valid, 1'b1);
      chk("a_idx",   a_idx,   64'(beat));
      chk("a_row",   a_row,   exp_row);
      chk("a_last",  a_last,  beat == AH - 1);
      chk("a_busy",  a_busy,  1'b1);
      chk("a_done",  a_done,  1'b0);
`ifdef LIFE_READER_POPCOUNT_EN
      chk("a_pop", a_pop, 64'($countones(exp_row)));
`endif
      case (mode)
        0:       a_ready = 1'b1;
        1:       a_ready = 1'($urandom_range(0, 1));
        default: begin
          a_ready = !(beat == 1 && stall < 5);
          if (!a_ready) stall++;
        end
      endcase
      tick();
      if (a_ready) beat++;
    end
    a_ready = 1'b0;
    chk("a_done_pulse", a_done,  1'b1);
    chk("a_done_valid", a_valid, 1'b0);
    chk("a_done_busy",  a_busy,  1'b1);
`ifdef LIFE_READER_POPCOUNT_EN
    chk("a_frame_pop", a_fpop, 64'($countones(g)));
`endif
    tick();
    chk_a_idle("a_after");
  endtask

  logic [11:0] g;
  logic [7:0]  bg;
  int          stalls;

  initial begin
    rst_n   = 1'b0;
    a_grid  = 12'h000; a_start = 1'b0; a_ready = 1'b0;
    b_grid  = 8'h00;   b_start = 1'b0; b_ready = 1'b0;
    tick();
    tick();
    chk_a_idle("rst");
    chk("rst_idx", a_idx, 2'd0);
    chk("rst_row", a_row, 4'h0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_b_done",  b_done,  1'b0);
    rst_n = 1'b1;
    tick();

    // Straight frame, consecutive beats.
    run_frame(12'hA5C, 0, 1'b0);
    // Backpressure on row 1.
    run_frame(12'($urandom), 2, 1'b0);
    // Grid flooded right after capture.
    run_frame(12'hA5C, 0, 1'b1);

    // start held high for the whole frame: one frame, then a new one only from IDLE.
    g       = 12'h3C9;
    a_grid  = g;
    a_start = 1'b1;
    a_ready = 1'b1;
    tick();
    for (int r = 0; r < AH; r++) begin
      chk("hold_idx", a_idx, 64'(r));
      chk("hold_row", a_row, 64'((g >> (r * AW)) & 12'hF));
      tick();
    end
    chk("hold_done",  a_done,  1'b1);
    chk("hold_valid", a_valid, 1'b0);
    tick();
    chk("hold_idle_valid", a_valid, 1'b0);
    chk("hold_idle_busy",  a_busy,  1'b0);
    tick();
    chk("hold_restart_valid", a_valid, 1'b1);
    chk("hold_restart_idx",   a_idx,   2'd0);
    a_start = 1'b0;
    for (int r = 0; r < AH; r++) tick();
    chk("hold2_done", a_done, 1'b1);
    a_ready = 1'b0;
    tick();

    // Randomized frames with random acceptance.
    for (int k = 0; k < 8; k++) run_frame(12'($urandom), 1, 1'b0);

    // out_ready with nothing valid.
    a_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a_idle("idle_ready");
    end
    a_ready = 1'b0;

    // Reset mid-frame: abort, no done.
    a_grid  = 12'hFFF;
    a_start = 1'b1;
    a_ready = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    chk("mid_idx", a_idx, 2'd1);
    rst_n = 1'b0;
    tick();
    tick();
    chk_a_idle("mid_rst");
    chk("mid_rst_idx", a_idx, 2'd0);
    chk("mid_rst_row", a_row, 4'h0);
    rst_n = 1'b1;
    tick();
    chk_a_idle("mid_post");
    a_ready = 1'b0;

    // Single-row grid.
    b_grid  = 8'h81;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_grid  = 8'h00;
    chk("b_valid", b_valid, 1'b1);
    chk("b_idx",   b_idx,   1'b0);
    chk("b_last",  b_last,  1'b1);
    chk("b_row",   b_row,   8'h81);
`ifdef LIFE_READER_POPCOUNT_EN
    chk("b_pop", b_pop, 4'd2);
`endif
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("b_done",  b_done,  1'b1);
    chk("b_dvalid", b_valid, 1'b0);
`ifdef LIFE_READER_POPCOUNT_EN
    chk("b_frame_pop", b_fpop, 4'd2);
`endif
    tick();
    chk("b_busy_after", b_busy, 1'b0);
    chk("b_done_after", b_done, 1'b0);

    for (int k = 0; k < 6; k++) begin
      bg      = 8'($urandom);
      stalls  = $urandom_range(0, 3);
      b_grid  = bg;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_grid  = ~bg;
      for (int s = 0; s < stalls; s++) begin
        chk("b_stall_row",   b_row,   bg);
        chk("b_stall_valid", b_valid, 1'b1);
        tick();
      end
      chk("b_rand_row",  b_row,  bg);
      chk("b_rand_last", b_last, 1'b1);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk("b_rand_done", b_done, 1'b1);
`ifdef LIFE_READER_POPCOUNT_EN
      chk("b_rand_fpop", b_fpop, 64'($countones(bg)));
`endif
      tick();
      chk("b_rand_idle", b_busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
